// File: rtl/if1_inst_queue_pkg.sv
// Shared definitions for the IF1 instruction queue: CPU word width and pointer helper.
package if1_inst_queue_pkg;

  localparam int WORD = 32;

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    if (ptr == depth - 32'd1) begin
      ptr_next = 32'd0;
    end else begin
      ptr_next = ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/if1_inst_queue.sv
// IF1 instruction queue: buffers fetched {pc, inst} pairs between IF1 and ID,
// with flush, early fetch stall and sticky overflow reporting.
module if1_inst_queue
  import if1_inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = WORD,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pc,
  input  logic [DW-1:0] in_inst,
  output logic          in_ready,
  output logic          fetch_stall,
  output logic          out_valid,
  output logic [DW-1:0] out_pc,
  output logic [DW-1:0] out_inst,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          overflow_err
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] pc_mem_q   [DEPTH];
  logic [DW-1:0] inst_mem_q [DEPTH];
  logic          push_s, pop_s;

  // Handshakes depend on registered occupancy only, so a pop never frees a slot for a same-cycle push.
  assign in_ready     = (count_q != CW'(DEPTH));
  assign out_valid    = (count_q != {CW{1'b0}});
  assign fetch_stall  = (count_q >= CW'(DEPTH - 2));
  assign count        = count_q;
  assign overflow_err = overflow_q;
  assign push_s       = in_valid && in_ready && !flush;
  assign pop_s        = out_valid && out_ready && !flush;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (in_valid && !in_ready && !flush);
    if (flush) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = PW'(ptr_next(32'(wr_ptr_q), 32'(DEPTH)));
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = PW'(ptr_next(32'(rd_ptr_q), 32'(DEPTH)));
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      pc_mem_q[wr_ptr_q]   <= in_pc;
      inst_mem_q[wr_ptr_q] <= in_inst;
    end
  end

  // Head entry presented to ID, forced to zero while empty.
  always_comb begin
    out_pc   = {DW{1'b0}};
    out_inst = {DW{1'b0}};
    if (out_valid) begin
      out_pc   = pc_mem_q[rd_ptr_q];
      out_inst = inst_mem_q[rd_ptr_q];
    end else begin
      out_pc   = {DW{1'b0}};
      out_inst = {DW{1'b0}};
    end
  end

endmodule

// File: tb/tb_if1_inst_queue.sv
// Directed scoreboard bench for if1_inst_queue: stimulus queues expected head
// entries, a negedge monitor checks every pop against them.
module tb_if1_inst_queue;

  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_pc;
  logic [DW-1:0] in_inst;
  logic          in_ready;
  logic          fetch_stall;
  logic          out_valid;
  logic [DW-1:0] out_pc;
  logic [DW-1:0] out_inst;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow_err;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [63:0] sb [$];

  if1_inst_queue #(.DEPTH(4), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready), .fetch_stall(fetch_stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; exp_push records an entry the queue must accept.
  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl, input logic exp_push);
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    if (fl) sb.delete();
    if (exp_push) sb.push_back({pc, inst});
  endtask

  // Monitor: every handshake that will pop must present the oldest expected entry.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !flush) begin
      pops++;
      if (sb.size() == 0) begin
        chk("pop_unexpected", {out_pc, out_inst}, 64'h0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("pop_entry", {out_pc, out_inst}, e);
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fetch_stall", 64'(fetch_stall), 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    rst = 1'b1;

    // Single push into empty queue, then pop it.
    drive(1'b1, 32'h1C000000, 32'h02800421, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("p1_out_valid", 64'(out_valid), 64'd1);
    chk("p1_out_pc", 64'(out_pc), 64'h1C000000);
    chk("p1_out_inst", 64'(out_inst), 64'h02800421);
    chk("p1_count", 64'(count), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk("p1_drained", 64'(count), 64'd0);

    // Fill to full; stall from two entries, then overflow attempt.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b1);
      step();
      chk("fill_count", 64'(count), 64'(i + 1));
      chk("fill_stall", 64'(fetch_stall), (i + 1 >= 2) ? 64'd1 : 64'd0);
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h555, 32'h555, 1'b0, 1'b0, 1'b0);
    step();
    chk("ovf_flag", 64'(overflow_err), 64'd1);
    chk("ovf_count", 64'(count), 64'd4);

    // Full with push and pop together: pop only.
    drive(1'b1, 32'h999, 32'h999, 1'b1, 1'b0, 1'b0);
    step();
    chk("fullpp_count", 64'(count), 64'd3);
    chk("fullpp_in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk("to2_count", 64'(count), 64'd2);

    // Steady push+pop at count 2 across pointer wrap.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 4), 32'hB0 + 32'(i), 1'b1, 1'b0, 1'b1);
      step();
      chk("pp_count", 64'(count), 64'd2);
    end

    // Flush at count 3 overrides push and pop.
    drive(1'b1, 32'h300, 32'hC0, 1'b0, 1'b0, 1'b1);
    step();
    chk("pre_flush_count", 64'(count), 64'd3);
    drive(1'b1, 32'h304, 32'hC1, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_pc", 64'(out_pc), 64'd0);

    // Reset mid-operation at count 2, then repeat the first push.
    drive(1'b1, 32'h400, 32'hD0, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("prerst_count", 64'(count), 64'd2);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    sb.delete();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_overflow", 64'(overflow_err), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h1C000000, 32'h02800421, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("p2_out_valid", 64'(out_valid), 64'd1);
    chk("p2_out_pc", 64'(out_pc), 64'h1C000000);
    chk("p2_count", 64'(count), 64'd1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("end_sb_empty", 64'(sb.size()), 64'd0);
    chk("end_pops", 64'(pops), 64'd10);
    chk("end_count", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
